// File: rtl/proc_trace_pkg.sv
// Shared definitions for the processor commit-trace buffer.
//
// Contents:
//   filter_mode_e : selects which committed instructions get captured
//   DROP_W        : width of the saturating drop counter
//   entryWidth()  : packed trace-entry width from the individual field widths
package proc_trace_pkg;

  typedef enum logic [1:0] {
    FILT_ALL = 2'b00,
    FILT_REG = 2'b01,
    FILT_MEM = 2'b10,
    FILT_ANY = 2'b11
  } filter_mode_e;

  localparam int DROP_W = 16;

  // Entry layout is {pc, inst, reg_en, reg_add, reg_data, mem_en, mem_add, mem_data}.
  function automatic int entryWidth(input int pcW, input int instW, input int regEnW,
                                    input int raddrW, input int dataW, input int maddrW);
    return pcW + instW + regEnW + raddrW + dataW + 1 + maddrW + dataW;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO used as trace storage.
//
// Parameters:
//   WIDTH     : entry width
//   DEPTH     : number of entries, power of two, >= 2
//   OVERWRITE : 0 = a push into a full FIFO is refused,
//               1 = a push into a full FIFO replaces the oldest entry
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   push_i      : write wdata_i this cycle
//   wdata_i     : entry to store
//   pop_i       : consume the head entry (ignored while empty)
//   rdata_o     : current head entry, combinational
//   count_o     : number of occupied entries
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
//   overflow_o  : push into a full FIFO without a same-cycle pop (refused or overwrote)
module trace_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  parameter bit OVERWRITE = 1'b0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPop;
  logic             doWrite;
  logic             overwrite;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being drained. When full, wrPtr equals rdPtr, so overwriting
  // writes on top of the oldest entry and the read pointer steps past it.
  assign doPop      = pop_i & ~empty_o;
  assign doWrite    = push_i & (~full_o | doPop | OVERWRITE);
  assign overwrite  = push_i & full_o & ~doPop & OVERWRITE;
  assign overflow_o = push_i & full_o & ~doPop;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doWrite) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop | overwrite) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (doWrite & ~doPop & ~overwrite) begin
      count_d = count_q + 1'b1;
    end else if (doPop & ~doWrite) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doWrite) begin
        mem_q[wrPtr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/proc_trace_buffer.sv
// Commit-trace capture buffer for the processor.
//
// Each committed instruction (PC, instruction word, register-file write and
// data-memory write) is optionally filtered, packed into one entry and stored
// in a DEPTH-entry FWFT FIFO that drains through a valid/ready port.
// Captures that cannot be stored (stop-on-full) or that displace the oldest
// entry (WRAP_MODE=1) are counted in a saturating drop counter.
// Reset release is expected to be synchronised to clk by the reset source.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cap_en                : capture enable
//   filter_mode           : 00 all, 01 reg-write only, 10 mem-write only, 11 either
//   commit_valid          : one instruction commits this cycle
//   pc, inst_out          : committed PC and instruction word
//   reg_en/add/data       : register-file write of the commit
//   mem_en/add/data       : data-memory write of the commit
//   trc_valid/ready/entry : trace readout, head entry shown combinationally
//   count, full, empty    : occupancy
//   drop_clr, drop_cnt    : clear and value of the drop counter
module proc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int INST_W    = 16,
  parameter int DATA_W    = 16,
  parameter int REG_EN_W  = 2,
  parameter int RADDR_W   = 3,
  parameter int MADDR_W   = 3,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 0,
  localparam int ENTRY_W  = entryWidth(PC_W, INST_W, REG_EN_W, RADDR_W, DATA_W, MADDR_W),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap_en,
  input  logic [1:0]          filter_mode,
  input  logic                commit_valid,
  input  logic [PC_W-1:0]     pc,
  input  logic [INST_W-1:0]   inst_out,
  input  logic [REG_EN_W-1:0] reg_en,
  input  logic [RADDR_W-1:0]  reg_add,
  input  logic [DATA_W-1:0]   reg_data,
  input  logic                mem_en,
  input  logic [MADDR_W-1:0]  mem_add,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                trc_valid,
  input  logic                trc_ready,
  output logic [ENTRY_W-1:0]  trc_entry,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  input  logic                drop_clr,
  output logic [DROP_W-1:0]   drop_cnt
);

  logic               matchHit;
  logic               pushReq;
  logic               popReq;
  logic               overflow;
  logic [ENTRY_W-1:0] packedEntry;
  logic [DROP_W-1:0]  dropCnt_q, dropCnt_d;

  always_comb begin
    matchHit = 1'b0;
    case (filter_mode_e'(filter_mode))
      FILT_ALL: matchHit = 1'b1;
      FILT_REG: matchHit = |reg_en;
      FILT_MEM: matchHit = mem_en;
      FILT_ANY: matchHit = (|reg_en) | mem_en;
      default:  matchHit = 1'b0;
    endcase
  end

  assign pushReq     = cap_en & commit_valid & matchHit;
  assign popReq      = trc_valid & trc_ready;
  assign trc_valid   = ~empty;
  assign packedEntry = {pc, inst_out, reg_en, reg_add, reg_data, mem_en, mem_add, mem_data};

  trace_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (WRAP_MODE != 0)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pushReq),
    .wdata_i    (packedEntry),
    .pop_i      (popReq),
    .rdata_o    (trc_entry),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  // Clear wins over a same-cycle drop; the counter sticks at all-ones.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (drop_clr) begin
      dropCnt_d = '0;
    end else if (overflow && (dropCnt_q != '1)) begin
      dropCnt_d = dropCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Scoreboard bench for proc_trace_buffer: one stop-on-full and one
// wrap-around instance share the commit stimulus and each has its own
// consumer ready. Captured entries are queued as expected readout; a
// negedge monitor pops and compares whenever a consumer takes the head.
module tb_proc_trace_buffer;

  localparam int DEPTH = 8;
  typedef logic [64:0] entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_en;
  logic [1:0]  filter_mode;
  logic        commit_valid;
  logic [7:0]  pc;
  logic [15:0] inst_out;
  logic [1:0]  reg_en;
  logic [2:0]  reg_add;
  logic [15:0] reg_data;
  logic        mem_en;
  logic [2:0]  mem_add;
  logic [15:0] mem_data;
  logic        drop_clr;

  logic        readyS, readyW;
  logic        validS, validW;
  entry_t      entryS, entryW;
  logic [3:0]  countS, countW;
  logic        fullS, fullW, emptyS, emptyW;
  logic [15:0] dropS, dropW;

  int checks = 0;
  int errors = 0;

  entry_t expS[$];
  entry_t expW[$];
  int     dropModelS = 0;
  int     dropModelW = 0;

  always #5 clk = ~clk;

  proc_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(0)) dutStop (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .filter_mode(filter_mode),
    .commit_valid(commit_valid), .pc(pc), .inst_out(inst_out),
    .reg_en(reg_en), .reg_add(reg_add), .reg_data(reg_data),
    .mem_en(mem_en), .mem_add(mem_add), .mem_data(mem_data),
    .trc_valid(validS), .trc_ready(readyS), .trc_entry(entryS),
    .count(countS), .full(fullS), .empty(emptyS),
    .drop_clr(drop_clr), .drop_cnt(dropS)
  );

  proc_trace_buffer #(.DEPTH(DEPTH), .WRAP_MODE(1)) dutWrap (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .filter_mode(filter_mode),
    .commit_valid(commit_valid), .pc(pc), .inst_out(inst_out),
    .reg_en(reg_en), .reg_add(reg_add), .reg_data(reg_data),
    .mem_en(mem_en), .mem_add(mem_add), .mem_data(mem_data),
    .trc_valid(validW), .trc_ready(readyW), .trc_entry(entryW),
    .count(countW), .full(fullW), .empty(emptyW),
    .drop_clr(drop_clr), .drop_cnt(dropW)
  );

  task automatic checkOutput(input string name, input entry_t act, input entry_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit filterMatch(input logic [1:0] mode, input logic [1:0] ren, input logic me);
    bit regWrite = (ren != 2'b00);
    case (mode)
      2'd0:    return 1'b1;
      2'd1:    return regWrite;
      2'd2:    return me;
      default: return regWrite || me;
    endcase
  endfunction

  // Reference model: what each consumer should eventually read, in order.
  always @(posedge clk) begin
    if (rst_n) begin
      entry_t e;
      bit     want;
      bit     dropEvS;
      bit     dropEvW;
      e = {pc, inst_out, reg_en, reg_add, reg_data, mem_en, mem_add, mem_data};
      want = cap_en && commit_valid && filterMatch(filter_mode, reg_en, mem_en);
      dropEvS = 1'b0;
      dropEvW = 1'b0;
      // The monitor has already removed this cycle's popped entries.
      if (want) begin
        if (expS.size() < DEPTH) expS.push_back(e);
        else dropEvS = 1'b1;
        if (expW.size() < DEPTH) expW.push_back(e);
        else begin
          void'(expW.pop_front());
          expW.push_back(e);
          dropEvW = 1'b1;
        end
      end
      if (drop_clr) dropModelS = 0;
      else if (dropEvS && dropModelS < 65535) dropModelS++;
      if (drop_clr) dropModelW = 0;
      else if (dropEvW && dropModelW < 65535) dropModelW++;
    end
  end

  always @(negedge rst_n) begin
    expS.delete();
    expW.delete();
    dropModelS = 0;
    dropModelW = 0;
  end

  // Monitor: occupancy every cycle, head contents whenever a consumer takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("validS", entry_t'(validS), entry_t'(expS.size() != 0));
      checkOutput("countS", entry_t'(countS), entry_t'(expS.size()));
      checkOutput("fullS",  entry_t'(fullS),  entry_t'(expS.size() == DEPTH));
      checkOutput("dropS",  entry_t'(dropS),  entry_t'(dropModelS));
      checkOutput("validW", entry_t'(validW), entry_t'(expW.size() != 0));
      checkOutput("countW", entry_t'(countW), entry_t'(expW.size()));
      checkOutput("fullW",  entry_t'(fullW),  entry_t'(expW.size() == DEPTH));
      checkOutput("dropW",  entry_t'(dropW),  entry_t'(dropModelW));
      if (readyS && expS.size() > 0) checkOutput("entryS", entryS, expS.pop_front());
      if (readyW && expW.size() > 0) checkOutput("entryW", entryW, expW.pop_front());
    end
  end

  task automatic applyStimulus(input logic cv, input logic [7:0] p,
                               input logic [1:0] ren, input logic me);
    commit_valid = cv;
    pc           = p;
    inst_out     = 16'($urandom);
    reg_en       = ren;
    reg_add      = 3'($urandom);
    reg_data     = 16'($urandom);
    mem_en       = me;
    mem_add      = 3'($urandom);
    mem_data     = 16'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cap_en = 1'b0; filter_mode = 2'b00; commit_valid = 1'b0;
    pc = '0; inst_out = '0; reg_en = '0; reg_add = '0; reg_data = '0;
    mem_en = 1'b0; mem_add = '0; mem_data = '0; drop_clr = 1'b0;
    readyS = 1'b0; readyW = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("rst_valid", entry_t'(validS), '0);
    checkOutput("rst_empty", entry_t'(emptyS), entry_t'(1));
    checkOutput("rst_full",  entry_t'(fullS),  '0);
    checkOutput("rst_count", entry_t'(countS), '0);
    checkOutput("rst_entry", entryS, '0);
    checkOutput("rst_entryW", entryW, '0);

    // Three captures held, then drained in order.
    cap_en = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h10 + i), 2'b01, 1'b0);
    idle(1);
    checkOutput("hold3_count", entry_t'(countS), entry_t'(3));
    checkOutput("hold3_headpc", entry_t'(entryS[64:57]), entry_t'(8'h10));
    readyS = 1'b1; readyW = 1'b1;
    idle(3);
    readyS = 1'b0; readyW = 1'b0;
    checkOutput("drain3_empty", entry_t'(emptyS), entry_t'(1));

    // Register-write filter ignores memory-only commits.
    filter_mode = 2'b01;
    applyStimulus(1'b1, 8'h20, 2'b00, 1'b1);
    applyStimulus(1'b1, 8'h21, 2'b01, 1'b0);
    applyStimulus(1'b1, 8'h22, 2'b00, 1'b1);
    applyStimulus(1'b1, 8'h23, 2'b10, 1'b0);
    idle(1);
    checkOutput("filt_count", entry_t'(countS), entry_t'(2));
    checkOutput("filt_head_ren", entry_t'(entryS[40:39]), entry_t'(2'b01));
    readyS = 1'b1; readyW = 1'b1;
    idle(1);
    checkOutput("filt_second_ren", entry_t'(entryS[40:39]), entry_t'(2'b10));
    idle(1);
    readyS = 1'b0; readyW = 1'b0;

    // Ten captures into eight slots, both capture policies.
    filter_mode = 2'b00;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 2'b00, 1'b0);
    idle(1);
    checkOutput("stop_count", entry_t'(countS), entry_t'(8));
    checkOutput("stop_drop", entry_t'(dropS), entry_t'(2));
    checkOutput("stop_headpc", entry_t'(entryS[64:57]), entry_t'(0));
    checkOutput("wrap_count", entry_t'(countW), entry_t'(8));
    checkOutput("wrap_drop", entry_t'(dropW), entry_t'(2));
    checkOutput("wrap_headpc", entry_t'(entryW[64:57]), entry_t'(2));
    readyS = 1'b1; readyW = 1'b1;
    idle(8);
    readyS = 1'b0; readyW = 1'b0;

    // Refill, then push and pop together while full.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h40 + i), 2'b00, 1'b0);
    readyS = 1'b1; readyW = 1'b1;
    applyStimulus(1'b1, 8'h50, 2'b00, 1'b0);
    readyS = 1'b0; readyW = 1'b0;
    idle(1);
    checkOutput("pp_countS", entry_t'(countS), entry_t'(8));
    checkOutput("pp_dropS", entry_t'(dropS), entry_t'(2));
    checkOutput("pp_countW", entry_t'(countW), entry_t'(8));
    checkOutput("pp_dropW", entry_t'(dropW), entry_t'(2));
    checkOutput("pp_headW", entry_t'(entryW[64:57]), entry_t'(8'h41));

    // Clear coinciding with a drop.
    drop_clr = 1'b1;
    applyStimulus(1'b1, 8'h60, 2'b00, 1'b0);
    drop_clr = 1'b0;
    idle(1);
    checkOutput("clr_dropS", entry_t'(dropS), '0);
    checkOutput("clr_dropW", entry_t'(dropW), '0);
    readyS = 1'b1; readyW = 1'b1;
    idle(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cap_en      = ($urandom_range(0, 9) != 0);
      filter_mode = 2'($urandom);
      readyS      = ($urandom_range(0, 2) == 0);
      readyW      = ($urandom_range(0, 2) == 0);
      drop_clr    = ($urandom_range(0, 30) == 0);
      applyStimulus(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
    end
    drop_clr = 1'b0;
    cap_en = 1'b0;
    applyStimulus(1'b1, 8'hEE, 2'b11, 1'b1);
    checkOutput("capen_off_drainW", entry_t'(countW <= 4'd8), entry_t'(1));
    readyS = 1'b1; readyW = 1'b1;
    idle(10);
    checkOutput("capen_off_emptyS", entry_t'(emptyS), entry_t'(1));

    // Asynchronous reset during a drain.
    cap_en = 1'b1;
    readyS = 1'b0; readyW = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h70 + i), 2'b00, 1'b0);
    readyS = 1'b1; readyW = 1'b1;
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_validS", entry_t'(validS), '0);
    checkOutput("arst_countS", entry_t'(countS), '0);
    checkOutput("arst_validW", entry_t'(validW), '0);
    checkOutput("arst_countW", entry_t'(countW), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    checkOutput("post_rst_empty", entry_t'(emptyS & emptyW), entry_t'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
